trace_tx: RTL



---
 rtl/trace_tx_if.sv | 19 +
 rtl/trace_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/trace_tx_if.sv
// trace_tx_if: byte stream carrying trace records, valid/ready handshake.
// master drives data/valid, slave drives ready.
interface trace_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/trace_tx.sv
// trace_tx: captures WB/MEM writes into a FIFO, streams tagged byte records.
// Optional TRACE_TS_EN adds a 16-bit capture timestamp after each tag.
module trace_tx #(
  parameter int         DEPTH  = 8,
  parameter logic [5:0] TAG_HI = 6'b101000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_regwrite,
  input  logic [31:0]            wb_regdata,
  input  logic                   mem_memwrite,
  input  logic [31:0]            mem_memdata,
  trace_tx_if.master             tx,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TS_EN
  localparam logic TS_BIT = 1'b1;
`else
  localparam logic TS_BIT = 1'b0;
`endif

  typedef struct packed {
`ifdef TRACE_TS_EN
    logic [15:0] ts;
`endif
    logic [1:0]  flags;
    logic [31:0] wb;
    logic [31:0] mem;
  } entry_t;

  typedef enum logic [3:0] {
    IDLE, TAG, TSH, TSL,
    R3, R2, R1, R0,
    M3, M2, M1, M0,
    DONE
  } state_e;

  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [7:0]    ovf_q;
  logic [7:0]    ovf_d;

  entry_t        cur_q;
  entry_t        head;
  entry_t        cap;
  state_e        state_q;
  state_e        nxt;
  state_e        first;
  state_e        tail;
  logic [7:0]    data_q;
  logic [7:0]    nxt_byte;
  logic          valid_q;

  logic          push;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          acc;
  logic          rec_end;

`ifdef TRACE_TS_EN
  logic [15:0]   ts_q;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 16'd1;
  end
`endif

  always_comb begin
    cap       = '0;
`ifdef TRACE_TS_EN
    cap.ts    = ts_q;
`endif
    cap.flags = {mem_memwrite, wb_regwrite};
    cap.wb    = wb_regdata;
    cap.mem   = mem_memdata;
  end

  assign head    = fifo_q[rd_q];
  assign acc     = valid_q && tx.tx_ready;
  assign push    = wb_regwrite | mem_memwrite;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign rec_end = acc && (nxt == DONE);
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop     = (cnt_q != '0) && ((state_q == IDLE) || rec_end);
  assign push_ok = push && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_ok && !pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop)
      cnt_d = cnt_q - (AW+1)'(1);
    if (push && !push_ok && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_q[wr_q] <= cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    first    = cur_q.flags[0] ? R3 : M3;
    tail     = cur_q.flags[1] ? M3 : DONE;
    nxt      = DONE;
    nxt_byte = 8'h00;
    unique case (state_q)
`ifdef TRACE_TS_EN
      TAG:     nxt = TSH;
      TSH:     nxt = TSL;
      TSL:     nxt = first;
`else
      TAG:     nxt = first;
`endif
      R3:      nxt = R2;
      R2:      nxt = R1;
      R1:      nxt = R0;
      R0:      nxt = tail;
      M3:      nxt = M2;
      M2:      nxt = M1;
      M1:      nxt = M0;
      default: nxt = DONE;
    endcase
    unique case (nxt)
`ifdef TRACE_TS_EN
      TSH:     nxt_byte = cur_q.ts[15:8];
      TSL:     nxt_byte = cur_q.ts[7:0];
`endif
      R3:      nxt_byte = cur_q.wb[31:24];
      R2:      nxt_byte = cur_q.wb[23:16];
      R1:      nxt_byte = cur_q.wb[15:8];
      R0:      nxt_byte = cur_q.wb[7:0];
      M3:      nxt_byte = cur_q.mem[31:24];
      M2:      nxt_byte = cur_q.mem[23:16];
      M1:      nxt_byte = cur_q.mem[15:8];
      M0:      nxt_byte = cur_q.mem[7:0];
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      state_q <= TAG;
      cur_q   <= head;
      data_q  <= {TAG_HI | {5'b0, TS_BIT}, head.flags};
      valid_q <= 1'b1;
    end else if (rec_end) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (acc) begin
      state_q <= nxt;
      data_q  <= nxt_byte;
    end
  end

  assign tx.tx_data   = data_q;
  assign tx.tx_valid  = valid_q;
  assign fifo_count   = cnt_q;
  assign overflow_cnt = ovf_q;
endmodule
